mul_div_unit: RTL and testbench

- Iterative multiply/divide execution unit directly downstream of the register file.
- Consumes the two read-port values (`data_a`, `data_b`) and the destination register address.
- Computes over WIDTH cycles, one bit per cycle, then presents a one-cycle write-back request (data + addrD + write enable) that feeds the register-file write port.
- Gives the monocycle core MUL/MULHU/DIVU/REMU without a combinational multiplier/divider on the critical path.

---
 rtl/mul_div_unit_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit_sign_fix.sv | 45 ++++
 rtl/mul_div_unit.sv | 131 +++++++++++++
 tb/tb_mul_div_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared widths, op encodings and FSM state encodings for the iterative mul/div unit
//   REG_FILE_WIDTH : default operand/result width
//   ADDR_WIDTH     : default register-file address width
//   md_op_e        : MUL / MULHU / DIVU / REMU operation codes
//   md_state_e     : IDLE / RUN / DONE sequencer states
package mul_div_unit_pkg;
    localparam int REG_FILE_WIDTH = 32;
    localparam int ADDR_WIDTH     = 5;

    typedef enum logic [1:0] {
        MD_OP_MUL   = 2'b00,
        MD_OP_MULHU = 2'b01,
        MD_OP_DIVU  = 2'b10,
        MD_OP_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/write-back bundle between the register file side and the mul/div unit
//   master (requester): drives start, op, signed_op, op_a, op_b, addr_d; observes ready, busy, done, result, wb_addr
//   slave  (unit)     : the mirror image
interface mul_div_unit_if #(
    parameter int WIDTH = mul_div_unit_pkg::REG_FILE_WIDTH,
    parameter int AW    = mul_div_unit_pkg::ADDR_WIDTH
) ();
    logic             start;
    logic [1:0]       op;
    logic             signed_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [AW-1:0]    addr_d;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [AW-1:0]    wb_addr;

    modport master (
        output start, op, signed_op, op_a, op_b, addr_d,
        input  ready, busy, done, result, wb_addr
    );

    modport slave (
        input  start, op, signed_op, op_a, op_b, addr_d,
        output ready, busy, done, result, wb_addr
    );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// mul_div_sign_fix: combinational sign handling around the unsigned mul/div core
//   a_i, b_i, signed_i      : raw operands at accept -> a_mag_o, b_mag_o magnitudes, neg_a_o, neg_b_o signs
//   op_i, neg_a_i, neg_b_i  : captured op and operand signs of the running operation
//   b_zero_i                : divisor was zero (quotient stays all ones)
//   prod_i, quo_i, rem_i    : unsigned core results -> res_o signed-corrected result
module mul_div_sign_fix
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = REG_FILE_WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    output logic               neg_a_o,
    output logic               neg_b_o,
    input  md_op_e             op_i,
    input  logic               neg_a_i,
    input  logic               neg_b_i,
    input  logic               b_zero_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quo_i,
    input  logic [WIDTH-1:0]   rem_i,
    output logic [WIDTH-1:0]   res_o
);
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign neg_a_o = signed_i & a_i[WIDTH-1];
    assign neg_b_o = signed_i & b_i[WIDTH-1];
    assign a_mag_o = neg_a_o ? -a_i : a_i;
    assign b_mag_o = neg_b_o ? -b_i : b_i;

    // A zero divisor keeps the all-ones quotient; the remainder is |a| re-signed, i.e. the dividend.
    // The most negative dividend over -1 falls out naturally as 0x8000_0000 / remainder 0.
    assign prod_s = (neg_a_i ^ neg_b_i) ? -prod_i : prod_i;
    assign quo_s  = ((neg_a_i ^ neg_b_i) && !b_zero_i) ? -quo_i : quo_i;
    assign rem_s  = neg_a_i ? -rem_i : rem_i;

    assign res_o = (op_i == MD_OP_MUL)   ? prod_s[WIDTH-1:0] :
                   (op_i == MD_OP_MULHU) ? prod_s[2*WIDTH-1:WIDTH] :
                   (op_i == MD_OP_DIVU)  ? quo_s : rem_s;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative one-bit-per-cycle MUL/MULHU/DIVU/REMU unit feeding the register-file write port
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mul_div_unit_if.slave (start/op/signed_op/op_a/op_b/addr_d in; ready/busy/done/result/wb_addr out)
//   Optional signed ops are built only when MUL_DIV_SIGNED_EN is defined.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = REG_FILE_WIDTH,
    parameter int AW    = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_e        state_q;
    md_op_e           op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [AW-1:0]    addr_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [AW-1:0]    wb_addr_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res_d;
    logic             ge;
    logic             accept;

    assign accept = bus.start && (state_q != MD_RUN);

    // hi_q/lo_q hold the product (multiply) or partial remainder/quotient (divide); b_q is multiplicand/divisor.
    assign sum  = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign ge   = sh >= {1'b0, b_q};
    assign hi_d = op_q[1] ? (ge ? sh - {1'b0, b_q} : sh) : {1'b0, sum[WIDTH:1]};
    assign lo_d = op_q[1] ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};

`ifdef MUL_DIV_SIGNED_EN
    logic neg_a_q, neg_b_q, neg_a_d, neg_b_d;

    mul_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i      (bus.op_a),
        .b_i      (bus.op_b),
        .signed_i (bus.signed_op),
        .a_mag_o  (a_in),
        .b_mag_o  (b_in),
        .neg_a_o  (neg_a_d),
        .neg_b_o  (neg_b_d),
        .op_i     (op_q),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .b_zero_i (b_q == '0),
        .prod_i   ({hi_d[WIDTH-1:0], lo_d}),
        .quo_i    (lo_d),
        .rem_i    (hi_d[WIDTH-1:0]),
        .res_o    (res_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (accept) begin
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end
`else
    assign a_in  = bus.op_a;
    assign b_in  = bus.op_b;
    // Low word / quotient live in lo, high word / remainder in hi.
    assign res_d = op_q[0] ? hi_d[WIDTH-1:0] : lo_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_OP_MUL;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            wb_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q <= MD_RUN;
                op_q    <= md_op_e'(bus.op);
                cnt_q   <= CW'(WIDTH);
                hi_q    <= '0;
                lo_q    <= a_in;
                b_q     <= b_in;
                addr_q  <= bus.addr_d;
                busy_q  <= 1'b1;
            end else if (state_q == MD_RUN) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_q   <= MD_DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    result_q  <= res_d;
                    wb_addr_q <= addr_q;
                end
            end else begin
                state_q <= MD_IDLE;
            end
        end
    end

    assign bus.ready   = state_q != MD_RUN;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.wb_addr = wb_addr_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus hand sequences for the iterative mul/div unit
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    typedef struct {
        logic [1:0]    op;
        logic          sgn;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] addr;
        logic [W-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W), .AW(AW)) bus ();

    mul_div_unit #(.WIDTH(W), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of busy cycle 1.
    task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [AW-1:0] addr);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.signed_op = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.addr_d    = addr;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.op_a      = ~a;
        bus.op_b      = ~b;
        bus.addr_d    = ~addr;
    endtask

    // Starts at cycle c0 after the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(input string name, input int c0, input logic [W-1:0] exp,
                             input logic [AW-1:0] addr);
        int cyc = c0;
        int bad = 0;
        while (!bus.done && cyc < 40) begin
            if (!bus.busy || bus.ready) bad++;
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, W'(cyc), W'(33));
        chk({name, " busy"}, W'(bad), '0);
        chk({name, " result"}, bus.result, exp);
        chk({name, " wb_addr"}, W'(bus.wb_addr), W'(addr));
        chk({name, " ready"}, W'(bus.ready), W'(1));
    endtask

    initial begin
        int dcount;
        vecs.push_back('{2'b00, 1'b0, 32'd7,         32'd6,         5'd5,  32'd42});
        vecs.push_back('{2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE});
        vecs.push_back('{2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0001});
        vecs.push_back('{2'b10, 1'b0, 32'd100,       32'd7,         5'd3,  32'd14});
        vecs.push_back('{2'b11, 1'b0, 32'd100,       32'd7,         5'd4,  32'd2});
        vecs.push_back('{2'b10, 1'b0, 32'd5,         32'd0,         5'd6,  32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 1'b0, 32'd5,         32'd0,         5'd7,  32'd5});
        vecs.push_back('{2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd8,  32'd0});
        vecs.push_back('{2'b01, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd9,  32'd1});
        vecs.push_back('{2'b10, 1'b0, 32'd3,         32'd7,         5'd10, 32'd0});
        vecs.push_back('{2'b11, 1'b0, 32'hFFFF_FFFF, 32'h10,        5'd11, 32'hF});
        vecs.push_back('{2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5,         5'd12, 32'hFFFF_FFF1});
        vecs.push_back('{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9});
`ifdef MUL_DIV_SIGNED_EN
        vecs.push_back('{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFD});
        vecs.push_back('{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd16, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000});
        vecs.push_back('{2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0});
        vecs.push_back('{2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'd0});
        vecs.push_back('{2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5,         5'd20, 32'hFFFF_FFFF});
`else
        vecs.push_back('{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'h7FFF_FFFC});
        vecs.push_back('{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd16, 32'h0000_0001});
        vecs.push_back('{2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0});
        vecs.push_back('{2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000});
        vecs.push_back('{2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE});
        vecs.push_back('{2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5,         5'd20, 32'd4});
`endif

        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.op        = 2'b00;
        bus.signed_op = 1'b0;
        bus.op_a      = 32'd3;
        bus.op_b      = 32'd3;
        bus.addr_d    = 5'd1;
        repeat (2) @(negedge clk);
        chk("reset busy", W'(bus.busy), '0);
        chk("reset ready", W'(bus.ready), W'(1));
        chk("reset done", W'(bus.done), '0);
        chk("reset result", bus.result, '0);
        chk("reset wb_addr", W'(bus.wb_addr), '0);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].addr);
            wait_done($sformatf("vec%0d", i), 1, vecs[i].exp, vecs[i].addr);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), W'(bus.done), '0);
            chk($sformatf("vec%0d held", i), bus.result, vecs[i].exp);
        end

        // start during RUN is ignored
        issue(2'b10, 1'b0, 32'd100, 32'd7, 5'd3);
        repeat (9) @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd3;
        bus.addr_d = 5'd7;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done("ignore", 11, 32'd14, 5'd3);
        @(negedge clk);
        chk("ignore no restart", W'(bus.busy), '0);

        // back-to-back: start accepted in the DONE cycle
        issue(2'b00, 1'b0, 32'd7, 32'd6, 5'd5);
        wait_done("b2b first", 1, 32'd42, 5'd5);
        issue(2'b11, 1'b0, 32'd100, 32'd7, 5'd9);
        chk("b2b result held", bus.result, 32'd42);
        wait_done("b2b second", 1, 32'd2, 5'd9);
        @(negedge clk);

        // reset mid-RUN aborts with no done pulse
        issue(2'b00, 1'b0, 32'hFFFF, 32'hFFFF, 5'd12);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort busy", W'(bus.busy), '0);
        chk("abort done", W'(bus.done), '0);
        chk("abort result", bus.result, '0);
        chk("abort wb_addr", W'(bus.wb_addr), '0);
        chk("abort ready", W'(bus.ready), W'(1));
        reset  = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        chk("abort no done", W'(dcount), '0);
        issue(2'b00, 1'b0, 32'd3, 32'd3, 5'd1);
        wait_done("after abort", 1, 32'd9, 5'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
